packet_switch_4x4: RTL and testbench
====================================

# packet_switch_4x4

Four-port, single-word-packet crossbar switch: each input port accepts 16-bit words tagged with a destination port and forwards them to the addressed output port. Each input has a 4-deep FIFO, and each output has its own round-robin arbiter and output register. It is the top-level design block exercised by the phase-6 verification environment, connected through the shared interface bundle.

## Interface
- NPORTS, 4: number of input and output ports (fixed; addresses are 2 bits).
- DW, 16: data word width.
- FIFO_DEPTH, 4: words per input FIFO.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; state clears on a rising edge while reset==0.
- in_valid  input  4  per-input word-valid.
- in_data  input  4x16  per-input word; bits [15:14] = destination port, bits [13:0] = payload.
- in_ready  output  4  per-input ready (FIFO not full).
- out_valid  output  4  per-output word-valid.
- out_data  output  4x16  per-output word, forwarded unmodified.
- out_src  output  4x2  input port the current output word came from.
- out_ready  input  4  per-output sink ready.

## Operation
- Input i accepts a word on an edge where in_valid[i] && in_ready[i]; the word is pushed into FIFO i.
- in_ready[i] = (count_i < 4), combinational from the registered count only. When FIFO i is full, in_ready[i]=0 even if a pop happens on the same edge (no pass-through).
- The head of FIFO i requests output port head[15:14].
- Output j owns an output register (out_valid[j], out_data[j], out_src[j]). The register is free when out_valid[j]==0, or when out_valid[j] && out_ready[j] on the current edge.
- Arbitration when output j is free:
  - Among inputs whose FIFO is non-empty and whose head targets j, grant one by round-robin.
  - Search starts at (last_grant_j + 1) mod 4.
  - last_grant_j resets to 3, so input 0 has first priority.
- On a grant: pop the head of FIFO i, load out_data[j] and out_src[j]=i, set out_valid[j]=1, and set last_grant_j=i.
- If there is no request and the register is drained, out_valid[j] goes to 0.
- While out_valid[j] && !out_ready[j], the register holds and no grant is issued.
- Each input pops at most one word per cycle. Its head targets only one output, so no input is ever granted twice in one cycle.
- Different outputs arbitrate independently in the same cycle. All four outputs may each load a word in a single cycle.
- Heads blocked behind a busy output stall their FIFO (head-of-line blocking is acceptable). Words are never dropped or reordered per input.
- Reset (reset==0 at an edge) clears:
  - all FIFOs (count=0, pointers=0)
  - out_valid=0, out_data=0, out_src=0
  - last_grant=3 for every output
  - therefore in_ready=4'b1111 after the reset edge
- Reset asserted mid-operation discards all buffered and pending words.

## Timing
- Minimum latency: a word accepted at edge N is visible on out_valid/out_data after edge N+1. It may not be forwarded combinationally.
- Sustained throughput: one word per cycle per output when out_ready is held high and requests are present.
- The out_valid/out_data contract is AXI-stream-like: once out_valid=1, data and source stay stable until the transfer edge (out_valid && out_ready).
- A FIFO pointer wraps modulo 4. A simultaneous push and pop with 0<count<4 keeps count unchanged.
- in_valid/in_data are sampled only on accepting edges. Values while in_ready==0 are ignored.

## Test plan
- Reset:
  - Drive reset=0 for one edge during traffic -> after that edge, out_valid=0, out_data=0, in_ready=4'b1111.
  - Previously queued words never appear at any output.
- Single path:
  - Input 2 sends 16'h4ABC (dst=1), out_ready=4'b1111.
  - The word is accepted at edge N -> after edge N+1, out_valid[1]=1, out_data[1]=16'h4ABC, out_src[1]=2.
  - No other output goes valid.
- Contention:
  - Inputs 0–3 each send one word to dst 3 in the same cycle, out_ready[3]=1.
  - The words appear on output 3 in source order 0,1,2,3 on consecutive cycles.
  - A second identical burst is then granted in order 0,1,2,3 again (pointer resets to 3 after granting 3).
- Backpressure and full:
  - out_ready[0]=0; input 1 sends 6 words to dst 0.
  - One word sits in the output register and 4 fill FIFO 1 -> in_ready[1]=0 and the sixth word is not accepted.
  - Raise out_ready -> all 5 accepted words emerge in order, then in_ready[1] returns to 1.
- Parallel:
  - Input i sends to dst (3-i) continuously with all outputs ready -> each output delivers one word per cycle with no stalls and no cross-talk.
- Stability:
  - Hold out_ready[2]=0 for 3 cycles with out_valid[2]=1 -> out_data[2] and out_src[2] are unchanged across those cycles.

Source files
------------

// File: rtl/packet_switch_4x4_if.sv
// Handshake bundle for packet_switch_4x4: per-port input words in, routed output words out.
// The switch connects through the slave modport; the traffic source/sink uses master.
interface packet_switch_4x4_if;
  localparam int unsigned NPORTS = 4;
  localparam int unsigned DW     = 16;

  logic [NPORTS-1:0]         in_valid;
  logic [NPORTS-1:0][DW-1:0] in_data;
  logic [NPORTS-1:0]         in_ready;
  logic [NPORTS-1:0]         out_valid;
  logic [NPORTS-1:0][DW-1:0] out_data;
  logic [NPORTS-1:0][1:0]    out_src;
  logic [NPORTS-1:0]         out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/packet_switch_4x4.sv
// 4x4 single-word packet crossbar: 4-deep FIFO per input, round-robin arbiter and
// registered output per destination port. Word bits [15:14] select the destination.
module packet_switch_4x4 (
  input  logic                clk,
  input  logic                reset,
  packet_switch_4x4_if.slave  bus
);
  localparam int unsigned NPORTS     = 4;
  localparam int unsigned DW         = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  logic [NPORTS-1:0][FIFO_DEPTH-1:0][DW-1:0] mem;
  logic [NPORTS-1:0][1:0]                    wr_ptr;
  logic [NPORTS-1:0][1:0]                    rd_ptr;
  logic [NPORTS-1:0][2:0]                    count;
  logic [NPORTS-1:0][DW-1:0]                 head;
  logic [NPORTS-1:0]                         ready_int;
  logic [NPORTS-1:0]                         push;
  logic [NPORTS-1:0]                         pop;

  logic [NPORTS-1:0]                         out_valid_q;
  logic [NPORTS-1:0][DW-1:0]                 out_data_q;
  logic [NPORTS-1:0][1:0]                    out_src_q;
  logic [NPORTS-1:0][1:0]                    last_grant;
  logic [NPORTS-1:0]                         free;
  logic [NPORTS-1:0]                         gnt_vld;
  logic [NPORTS-1:0][1:0]                    gnt_idx;

  assign bus.in_ready  = ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    pop     = '0;
    gnt_vld = '0;
    gnt_idx = '0;
    free    = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      head[i]      = mem[i][rd_ptr[i]];
      ready_int[i] = (count[i] < 3'(FIFO_DEPTH));
      push[i]      = bus.in_valid[i] && ready_int[i];
    end
    // Search order wraps through 2-bit addition; k==NPORTS lands on last_grant itself.
    for (int unsigned j = 0; j < NPORTS; j++) begin
      free[j] = !out_valid_q[j] || bus.out_ready[j];
      if (free[j]) begin
        for (int unsigned k = 1; k <= NPORTS; k++) begin
          idx = last_grant[j] + 2'(k);
          if (!gnt_vld[j] && (count[idx] != 3'd0) && (head[idx][DW-1:DW-2] == 2'(j))) begin
            gnt_vld[j] = 1'b1;
            gnt_idx[j] = idx;
          end
        end
      end
      if (gnt_vld[j]) pop[gnt_idx[j]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      last_grant  <= '1;
    end else begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= bus.in_data[i];
          wr_ptr[i]         <= wr_ptr[i] + 2'd1;
        end
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 2'd1;
        count[i] <= count[i] + 3'(push[i]) - 3'(pop[i]);
      end
      for (int unsigned j = 0; j < NPORTS; j++) begin
        if (free[j]) begin
          out_valid_q[j] <= gnt_vld[j];
          if (gnt_vld[j]) begin
            out_data_q[j] <= head[gnt_idx[j]];
            out_src_q[j]  <= gnt_idx[j];
            last_grant[j] <= gnt_idx[j];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_packet_switch_4x4.sv
// Self-checking bench for packet_switch_4x4: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the switching rules.
module tb_packet_switch_4x4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  packet_switch_4x4_if bus ();

  packet_switch_4x4 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mq [4][$];
  logic [3:0]  m_valid;
  logic [15:0] m_data [4];
  int          m_src  [4];
  int          m_last [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the stimulus present before the edge.
  task automatic model_step();
    bit [3:0]    rdy;
    bit [3:0]    popm;
    logic [15:0] w;
    bit          found;
    int          s;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        m_data[i] = '0;
        m_src[i]  = 0;
        m_last[i] = 3;
      end
      m_valid = '0;
      return;
    end
    popm = '0;
    for (int i = 0; i < 4; i++) rdy[i] = (mq[i].size() < 4);
    for (int j = 0; j < 4; j++) begin
      if (!m_valid[j] || bus.out_ready[j]) begin
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          s = (m_last[j] + k) % 4;
          if (!found && mq[s].size() > 0) begin
            w = mq[s][0];
            if (int'(w[15:14]) == j) begin
              found      = 1;
              m_data[j]  = w;
              m_src[j]   = s;
              m_last[j]  = s;
              popm[s]    = 1'b1;
            end
          end
        end
        m_valid[j] = found;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (popm[i]) void'(mq[i].pop_front());
      if (bus.in_valid[i] && rdy[i]) mq[i].push_back(bus.in_data[i]);
    end
  endtask

  task automatic cycle();
    logic [3:0] exp_rdy;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) exp_rdy[i] = (mq[i].size() < 4);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    for (int j = 0; j < 4; j++)
      if (m_valid[j])
        chk($sformatf("out_word%0d", j), {14'd0, bus.out_data[j], bus.out_src[j]},
            {14'd0, m_data[j], 2'(m_src[j])});
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = '1;

    // Reset
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'hF);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data[0] | bus.out_data[1] | bus.out_data[2] | bus.out_data[3]), 32'h0);

    // Single path: input 2 -> output 1
    bus.in_valid   = 4'b0100;
    bus.in_data[2] = 16'h4ABC;
    cycle();
    bus.in_valid = '0;
    cycle();
    chk("single_valid", 32'(bus.out_valid), 32'h2);
    chk("single_data", 32'(bus.out_data[1]), 32'h4ABC);
    chk("single_src", 32'(bus.out_src[1]), 32'h2);
    cycle();

    // Contention: two bursts of all inputs to output 3
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = '1;
      for (int i = 0; i < 4; i++) bus.in_data[i] = 16'hC000 | 16'(i + 16 * b);
      cycle();
      bus.in_valid = '0;
      for (int k = 0; k < 4; k++) begin
        cycle();
        chk("contend_src", 32'(bus.out_src[3]), 32'(k));
        chk("contend_data", 32'(bus.out_data[3]), 32'(16'hC000 | 16'(k + 16 * b)));
      end
    end
    cycle();

    // Backpressure and full FIFO on input 1 -> output 0
    bus.out_ready = 4'b1110;
    bus.in_valid  = 4'b0010;
    for (int n = 0; n < 6; n++) begin
      bus.in_data[1] = 16'h0100 + 16'(n);
      cycle();
    end
    bus.in_valid = '0;
    chk("full_in_ready1", 32'(bus.in_ready[1]), 32'h0);
    chk("bp_head", 32'(bus.out_data[0]), 32'h0100);
    bus.out_ready = '1;
    for (int n = 1; n < 5; n++) begin
      cycle();
      chk("bp_drain", 32'(bus.out_data[0]), 32'(16'h0100 + 16'(n)));
    end
    chk("bp_ready_back", 32'(bus.in_ready[1]), 32'h1);
    cycle();
    chk("bp_empty", 32'(bus.out_valid[0]), 32'h0);

    // Stability under held backpressure on output 2
    bus.out_ready  = 4'b1011;
    bus.in_valid   = 4'b0001;
    bus.in_data[0] = 16'h8055;
    cycle();
    bus.in_valid = '0;
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("stable_data", 32'(bus.out_data[2]), 32'h8055);
      chk("stable_src", 32'(bus.out_src[2]), 32'h0);
    end
    bus.out_ready = '1;
    cycle();

    // Parallel: input i -> output 3-i every cycle
    bus.in_valid = '1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) bus.in_data[i] = {2'(3 - i), 14'(n * 4 + i)};
      cycle();
      if (n >= 1) begin
        chk("par_valid", 32'(bus.out_valid), 32'hF);
        for (int j = 0; j < 4; j++) chk("par_src", 32'(bus.out_src[j]), 32'(3 - j));
      end
    end
    bus.in_valid = '0;
    cycle();
    cycle();

    // Random traffic with one mid-stream reset
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = 4'($urandom_range(0, 15));
      bus.out_ready = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) bus.in_data[i] = 16'($urandom);
      reset = (n != 200);
      cycle();
      if (n == 200) begin
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'hF);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_out_data", 32'(bus.out_data[0] | bus.out_data[1] | bus.out_data[2] | bus.out_data[3]), 32'h0);
      end
    end
    reset        = 1'b1;
    bus.in_valid = '0;
    bus.out_ready = '1;
    for (int n = 0; n < 20; n++) cycle();
    chk("final_empty", 32'(bus.out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
